booth_mul_param: RTL and testbench

Sequential radix-2 Booth multiplier, parametrised in operand width, with a per-operation signed/unsigned mode and a start/busy/done handshake. It generalises the fixed 4-bit Booth multiplier to any width of at least 2. It sits in the datapath as a multi-cycle multiply unit: a controller pulses or holds `start`, then waits for `done`.

---
 rtl/booth_mul_param.sv | 117 +++++++++++
 tb/tb_booth_mul_param.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/booth_mul_param.sv
// Sequential radix-2 Booth multiplier: WIDTH-bit operands, per-operation signed/unsigned
// mode, start/busy/done handshake, 2*WIDTH-bit registered product after WIDTH+1 iterations.
module booth_mul_param #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH+2)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     input1,
  input  logic [WIDTH-1:0]     input2,
  output logic [2*WIDTH-1:0]   result,
  output logic [CW-1:0]        count,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [WIDTH+1:0]     a_q, a_d;
  logic [WIDTH+1:0]     m_q, m_d;
  logic [WIDTH:0]       q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic [WIDTH:0]       ext1, ext2;
  logic [WIDTH+1:0]     a_sum;
  logic [2*WIDTH+3:0]   shifted;
  logic [WIDTH+1:0]     a_sh;
  logic [WIDTH:0]       q_sh;
  logic                 qm1_sh;
  logic                 last_iter;

  // One extra operand bit keeps unsigned max and signed min exact in the Booth recoding.
  always_comb begin
    ext1 = {signed_mode & input1[WIDTH-1], input1};
    ext2 = {signed_mode & input2[WIDTH-1], input2};
  end

  always_comb begin
    a_sum = a_q;
    case ({q_q[0], qm1_q})
      2'b01:   a_sum = a_q + m_q;
      2'b10:   a_sum = a_q - m_q;
      default: a_sum = a_q;
    endcase
    shifted   = {a_sum[WIDTH+1], a_sum, q_q};
    a_sh      = shifted[2*WIDTH+3:WIDTH+2];
    q_sh      = shifted[WIDTH+1:1];
    qm1_sh    = shifted[0];
    last_iter = (count_q == CW'(WIDTH));
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    m_d      = m_q;
    q_d      = q_q;
    qm1_d    = qm1_q;
    count_d  = count_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = {ext1[WIDTH], ext1};
          a_d     = '0;
          q_d     = ext2;
          qm1_d   = 1'b0;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_sh;
        q_d     = q_sh;
        qm1_d   = qm1_sh;
        count_d = count_q + CW'(1);
        if (last_iter) begin
          // Full product fits in the low 2*WIDTH bits of {A,Q}.
          result_d = {a_sh[WIDTH-2:0], q_sh};
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      m_q      <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      m_q      <= m_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;
  assign count  = count_q;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_booth_mul_param.sv
// Directed bench for booth_mul_param at WIDTH=4 and WIDTH=8 with hand-computed products.
module tb_booth_mul_param;
  logic       clk = 1'b0;
  logic       reset;
  logic       start4, sm4;
  logic [3:0] a4, b4;
  logic [7:0] res4;
  logic [2:0] cnt4;
  logic       busy4, done4;
  logic       start8, sm8;
  logic [7:0] a8, b8;
  logic [15:0] res8;
  logic [3:0] cnt8;
  logic       busy8, done8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  booth_mul_param #(.WIDTH(4)) u4 (
    .clk(clk), .reset(reset), .start(start4), .signed_mode(sm4),
    .input1(a4), .input2(b4), .result(res4), .count(cnt4), .busy(busy4), .done(done4)
  );

  booth_mul_param #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
    .input1(a8), .input2(b8), .result(res8), .count(cnt8), .busy(busy8), .done(done8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op4(input logic sm, input logic [3:0] a, input logic [3:0] b,
                     input logic [7:0] exp, input string tag);
    int lat;
    lat = 0;
    @(negedge clk); sm4 = sm; a4 = a; b4 = b; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) chk({tag, ".busy"}, 32'(busy4), 32'd1);
      if (done4) begin lat = k; break; end
    end
    chk({tag, ".lat"}, lat, 32'd5);
    chk({tag, ".res"}, 32'(res4), 32'(exp));
    chk({tag, ".cnt"}, 32'(cnt4), 32'd5);
    @(negedge clk);
    chk({tag, ".done_fall"}, 32'(done4), 32'd0);
    chk({tag, ".busy_fall"}, 32'(busy4), 32'd0);
    chk({tag, ".res_hold"}, 32'(res4), 32'(exp));
  endtask

  task automatic op8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp, input string tag);
    int lat;
    lat = 0;
    @(negedge clk); sm8 = sm; a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done8) begin lat = k; break; end
    end
    chk({tag, ".lat"}, lat, 32'd9);
    chk({tag, ".res"}, 32'(res8), 32'(exp));
    chk({tag, ".cnt"}, 32'(cnt8), 32'd9);
    @(negedge clk);
    chk({tag, ".done_fall"}, 32'(done8), 32'd0);
  endtask

  initial begin
    int d1, d2, n;
    reset = 1'b0;
    start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    @(negedge clk); @(negedge clk);
    chk("rst.res4", 32'(res4), 32'd0);
    chk("rst.cnt4", 32'(cnt4), 32'd0);
    chk("rst.busy4", 32'(busy4), 32'd0);
    chk("rst.done4", 32'(done4), 32'd0);
    chk("rst.res8", 32'(res8), 32'd0);
    chk("rst.busy8", 32'(busy8), 32'd0);
    reset = 1'b1;

    // start held high: done at E5, next done 7 cycles later
    @(negedge clk); sm4 = 1'b0; a4 = 4'd4; b4 = 4'd5; start4 = 1'b1;
    d1 = -1; d2 = -1;
    for (int t = 0; t <= 30; t++) begin
      @(negedge clk);
      if (done4) begin
        if (d1 < 0) begin
          d1 = t;
          chk("held.res1", 32'(res4), 32'h14);
          chk("held.cnt1", 32'(cnt4), 32'd5);
        end else begin
          d2 = t;
          start4 = 1'b0;
          break;
        end
      end
    end
    chk("held.lat", d1, 32'd5);
    chk("held.gap", d2 - d1, 32'd7);
    chk("held.res2", 32'(res4), 32'h14);
    @(negedge clk); @(negedge clk);
    chk("held.stop", 32'(busy4), 32'd0);

    op4(1'b0, 4'hF, 4'hF, 8'hE1, "u15x15");
    op4(1'b1, 4'hF, 4'hF, 8'h01, "sm1xm1");
    op4(1'b1, 4'h8, 4'h7, 8'hC8, "sm8x7");
    op4(1'b1, 4'h8, 4'h8, 8'h40, "sm8xm8");
    op4(1'b0, 4'h8, 4'hF, 8'h78, "u8x15");

    // operands and start disturbed during RUN
    @(negedge clk); sm4 = 1'b1; a4 = 4'd5; b4 = 4'hD; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    d1 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done4) begin d1 = k; break; end
      start4 = (k <= 3) && (k % 2 == 1);
      a4 = 4'($urandom); b4 = 4'($urandom); sm4 = ~sm4;
    end
    start4 = 1'b0;
    chk("tog.lat", d1, 32'd5);
    chk("tog.res", 32'(res4), 32'hF1);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done4) n++;
    end
    chk("tog.extra_done", n, 32'd0);
    chk("tog.busy", 32'(busy4), 32'd0);

    // asynchronous reset at E3 of an operation
    @(negedge clk); sm4 = 1'b0; a4 = 4'd7; b4 = 4'd6; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("arst.res", 32'(res4), 32'd0);
    chk("arst.cnt", 32'(cnt4), 32'd0);
    chk("arst.busy", 32'(busy4), 32'd0);
    chk("arst.done", 32'(done4), 32'd0);
    n = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done4) n++;
    end
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done4 || busy4) n++;
    end
    chk("arst.no_done", n, 32'd0);
    op4(1'b0, 4'd3, 4'd3, 8'h09, "post3x3");

    op8(1'b1, 8'h80, 8'h80, 16'h4000, "w8.sm128");
    op8(1'b0, 8'hFF, 8'hFF, 16'hFE01, "w8.u255");
    op8(1'b1, 8'h7F, 8'h80, 16'hC080, "w8.s127xm128");
    op8(1'b0, 8'd200, 8'd3, 16'h0258, "w8.u200x3");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
